// File: rtl/execute_hazard_ctrl_pkg.sv
// Shared encodings for the execute-stage hazard controller: forwarding selects,
// result-source codes and the mul/div sequencing FSM state type.
package execute_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/execute_hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// slave = the controller itself, master = the pipeline/datapath driving it.
interface execute_hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic [REG_ADDR_WIDTH-1:0] rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_e;
    logic [REG_ADDR_WIDTH-1:0] rs2_e;
    logic [REG_ADDR_WIDTH-1:0] rd_e;
    logic [1:0]                res_src_e;
    logic                      pc_src_e;
    logic [REG_ADDR_WIDTH-1:0] rd_m;
    logic [REG_ADDR_WIDTH-1:0] rd_w;
    logic                      reg_write_m;
    logic                      reg_write_w;
    logic                      muldiv_e;
    logic                      muldiv_done;
    logic                      cnt_clr;

    logic [1:0]                forward_a_e;
    logic [1:0]                forward_b_e;
    logic                      stall_f;
    logic                      stall_d;
    logic                      stall_e;
    logic                      flush_d;
    logic                      flush_e;
    logic                      bubble_m;
    logic                      muldiv_start;
    logic                      md_busy;
    logic [CNT_WIDTH-1:0]      load_stall_cnt;
    logic [CNT_WIDTH-1:0]      md_stall_cnt;

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, pc_src_e,
               rd_m, rd_w, reg_write_m, reg_write_w, muldiv_e, muldiv_done, cnt_clr,
        output forward_a_e, forward_b_e, stall_f, stall_d, stall_e, flush_d, flush_e,
               bubble_m, muldiv_start, md_busy, load_stall_cnt, md_stall_cnt
    );

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, pc_src_e,
               rd_m, rd_w, reg_write_m, reg_write_w, muldiv_e, muldiv_done, cnt_clr,
        input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e, flush_d, flush_e,
               bubble_m, muldiv_start, md_busy, load_stall_cnt, md_stall_cnt
    );

endinterface

// File: rtl/execute_hazard_ctrl_sat_counter.sv
// Cycle counter that sticks at all-ones instead of wrapping; clear beats increment.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/execute_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stalls,
// branch flushes, mul/div start/done sequencing and stall perf counters.
module execute_hazard_ctrl
    import execute_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    execute_hazard_ctrl_if.slave  bus
);

    logic [REG_ADDR_WIDTH-1:0] w_rs_e [2];
    md_state_t                 r_state;
    md_state_t                 w_state_next;
    logic                      w_start;
    logic                      w_md_stall;
    logic                      w_lw_stall;

    assign w_rs_e[0] = bus.rs1_e;
    assign w_rs_e[1] = bus.rs2_e;

    // Same priority chain for both operands: the younger M result shadows W.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [1:0] w_sel;
        always_comb begin
            w_sel = FWD_REG;
            if (bus.reg_write_m && (bus.rd_m != '0) && (bus.rd_m == w_rs_e[gi])) begin
                w_sel = FWD_MEM;
            end else if (bus.reg_write_w && (bus.rd_w != '0) && (bus.rd_w == w_rs_e[gi])) begin
                w_sel = FWD_WB;
            end
        end
    end

    assign bus.forward_a_e = g_fwd[0].w_sel;
    assign bus.forward_b_e = g_fwd[1].w_sel;

    assign w_lw_stall = (bus.res_src_e == RES_MEM) && (bus.rd_e != '0) &&
                        ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A taken branch in E suppresses the start; the done cycle releases the stall
    // so the finished op leaves E on the same edge the FSM returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_md_stall   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.muldiv_e && !bus.pc_src_e) begin
                    w_start      = 1'b1;
                    w_md_stall   = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.muldiv_done) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_md_stall   = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.muldiv_start = w_start;
    assign bus.md_busy      = (r_state == ST_BUSY);
    assign bus.stall_f      = w_md_stall | w_lw_stall;
    assign bus.stall_d      = w_md_stall | w_lw_stall;
    assign bus.stall_e      = w_md_stall;
    assign bus.bubble_m     = w_md_stall;
    assign bus.flush_d      = bus.pc_src_e & ~w_md_stall;
    assign bus.flush_e      = (w_lw_stall | bus.pc_src_e) & ~w_md_stall;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_lw_stall & ~w_md_stall),
        .i_clr (bus.cnt_clr),
        .o_cnt (bus.load_stall_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_md_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_md_stall),
        .i_clr (bus.cnt_clr),
        .o_cnt (bus.md_stall_cnt)
    );

endmodule

// File: tb/tb_execute_hazard_ctrl.sv
// Directed bench for execute_hazard_ctrl; a 4-bit counter width keeps saturation reachable.
module tb_execute_hazard_ctrl;

    localparam int RAW = 5;
    localparam int CW  = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    execute_hazard_ctrl_if #(.REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) bus ();

    execute_hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rs1_d = '0; bus.rs2_d = '0; bus.rs1_e = '0; bus.rs2_e = '0; bus.rd_e = '0;
        bus.res_src_e = 2'b00; bus.pc_src_e = 1'b0; bus.rd_m = '0; bus.rd_w = '0;
        bus.reg_write_m = 1'b0; bus.reg_write_w = 1'b0; bus.muldiv_e = 1'b0;
        bus.muldiv_done = 1'b0; bus.cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        checks++; if ({bus.forward_a_e, bus.forward_b_e} !== 4'b0000) begin errors++; $display("FAIL rst_fwd: got %b expected 0000", {bus.forward_a_e, bus.forward_b_e}); end
        checks++; if ({bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_d, bus.flush_e, bus.bubble_m, bus.muldiv_start, bus.md_busy} !== 8'h00) begin errors++; $display("FAIL rst_ctrl: got %b expected 00000000", {bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_d, bus.flush_e, bus.bubble_m, bus.muldiv_start, bus.md_busy}); end
        checks++; if ({bus.load_stall_cnt, bus.md_stall_cnt} !== 8'h00) begin errors++; $display("FAIL rst_cnt: got %h expected 00", {bus.load_stall_cnt, bus.md_stall_cnt}); end
        rst_n = 1'b1;
        step();
        $display("txn reset done");
    endtask

    task automatic test_forwarding();
        bus.rd_m = 5'd5; bus.reg_write_m = 1'b1; bus.rd_w = 5'd5; bus.reg_write_w = 1'b1;
        bus.rs1_e = 5'd5; bus.rs2_e = 5'd0;
        #1;
        checks++; if (bus.forward_a_e !== 2'b01) begin errors++; $display("FAIL fwd_m_wins: got %b expected 01", bus.forward_a_e); end
        checks++; if (bus.forward_b_e !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b expected 00", bus.forward_b_e); end
        bus.rd_m = 5'd0;
        #1;
        checks++; if (bus.forward_a_e !== 2'b10) begin errors++; $display("FAIL fwd_w_rdm0: got %b expected 10", bus.forward_a_e); end
        bus.rd_m = 5'd9; bus.rs2_e = 5'd9; bus.reg_write_m = 1'b0;
        #1;
        checks++; if (bus.forward_b_e !== 2'b00) begin errors++; $display("FAIL fwd_no_regwrite_m: got %b expected 00", bus.forward_b_e); end
        bus.reg_write_m = 1'b1; bus.reg_write_w = 1'b0;
        #1;
        checks++; if ({bus.forward_a_e, bus.forward_b_e} !== 4'b0001) begin errors++; $display("FAIL fwd_b_m: got %b expected 0001", {bus.forward_a_e, bus.forward_b_e}); end
        clear_inputs();
        step();
        $display("txn forwarding done");
    endtask

    task automatic test_load_use();
        bus.res_src_e = 2'b01; bus.rd_e = 5'd7; bus.rs2_d = 5'd7;
        #1;
        checks++; if ({bus.stall_f, bus.stall_d, bus.flush_e} !== 3'b111) begin errors++; $display("FAIL lu_stall: got %b expected 111", {bus.stall_f, bus.stall_d, bus.flush_e}); end
        checks++; if ({bus.stall_e, bus.flush_d, bus.bubble_m} !== 3'b000) begin errors++; $display("FAIL lu_other: got %b expected 000", {bus.stall_e, bus.flush_d, bus.bubble_m}); end
        step();
        clear_inputs();
        #1;
        checks++; if (bus.load_stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", bus.load_stall_cnt); end
        checks++; if (bus.stall_f !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", bus.stall_f); end
        bus.res_src_e = 2'b01; bus.rd_e = 5'd0; bus.rs1_d = 5'd0;
        #1;
        checks++; if (bus.stall_f !== 1'b0) begin errors++; $display("FAIL lu_x0: got %b expected 0", bus.stall_f); end
        bus.rd_e = 5'd3; bus.rs1_d = 5'd3; bus.res_src_e = 2'b00;
        #1;
        checks++; if (bus.stall_f !== 1'b0) begin errors++; $display("FAIL lu_alu_src: got %b expected 0", bus.stall_f); end
        clear_inputs();
        step();
        $display("txn load_use done");
    endtask

    task automatic test_branch();
        bus.pc_src_e = 1'b1;
        #1;
        checks++; if ({bus.flush_d, bus.flush_e, bus.stall_f, bus.stall_d, bus.stall_e} !== 5'b11000) begin errors++; $display("FAIL br_plain: got %b expected 11000", {bus.flush_d, bus.flush_e, bus.stall_f, bus.stall_d, bus.stall_e}); end
        step();
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL br_idle: got %b expected 0", bus.md_busy); end
        bus.res_src_e = 2'b01; bus.rd_e = 5'd4; bus.rs1_d = 5'd4;
        #1;
        checks++; if ({bus.flush_d, bus.flush_e, bus.stall_f} !== 3'b111) begin errors++; $display("FAIL br_with_lu: got %b expected 111", {bus.flush_d, bus.flush_e, bus.stall_f}); end
        step();
        checks++; if (bus.load_stall_cnt !== 4'd2) begin errors++; $display("FAIL br_lu_cnt: got %0d expected 2", bus.load_stall_cnt); end
        clear_inputs();
        bus.pc_src_e = 1'b1; bus.muldiv_e = 1'b1;
        #1;
        checks++; if ({bus.muldiv_start, bus.flush_d, bus.flush_e, bus.stall_e} !== 4'b0110) begin errors++; $display("FAIL br_vs_md: got %b expected 0110", {bus.muldiv_start, bus.flush_d, bus.flush_e, bus.stall_e}); end
        step();
        checks++; if ({bus.md_busy, bus.md_stall_cnt} !== 5'b0_0000) begin errors++; $display("FAIL br_md_nostart: got %b expected 00000", {bus.md_busy, bus.md_stall_cnt}); end
        clear_inputs();
        step();
        $display("txn branch done");
    endtask

    task automatic test_muldiv();
        bus.muldiv_done = 1'b1;
        #1;
        checks++; if ({bus.stall_e, bus.muldiv_start, bus.md_busy} !== 3'b000) begin errors++; $display("FAIL md_done_idle: got %b expected 000", {bus.stall_e, bus.muldiv_start, bus.md_busy}); end
        step();
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL md_done_idle_state: got %b expected 0", bus.md_busy); end
        bus.muldiv_done = 1'b0;
        bus.muldiv_e = 1'b1;
        #1;
        checks++; if ({bus.muldiv_start, bus.stall_e, bus.bubble_m, bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.md_busy} !== 8'b11111000) begin errors++; $display("FAIL md_cyc0: got %b expected 11111000", {bus.muldiv_start, bus.stall_e, bus.bubble_m, bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.md_busy}); end
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++; if ({bus.muldiv_start, bus.stall_e, bus.bubble_m, bus.md_busy} !== 4'b0111) begin errors++; $display("FAIL md_busy_cyc%0d: got %b expected 0111", c, {bus.muldiv_start, bus.stall_e, bus.bubble_m, bus.md_busy}); end
        end
        step();
        bus.muldiv_done = 1'b1;
        #1;
        checks++; if ({bus.muldiv_start, bus.stall_e, bus.bubble_m, bus.stall_f, bus.md_busy} !== 5'b00001) begin errors++; $display("FAIL md_done_cyc: got %b expected 00001", {bus.muldiv_start, bus.stall_e, bus.bubble_m, bus.stall_f, bus.md_busy}); end
        step();
        clear_inputs();
        #1;
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL md_back_idle: got %b expected 0", bus.md_busy); end
        checks++; if (bus.md_stall_cnt !== 4'd4) begin errors++; $display("FAIL md_cnt: got %0d expected 4", bus.md_stall_cnt); end
        step();
        $display("txn muldiv done");
    endtask

    task automatic test_back_to_back();
        bus.muldiv_e = 1'b1;
        #1;
        checks++; if (bus.muldiv_start !== 1'b1) begin errors++; $display("FAIL b2b_start1: got %b expected 1", bus.muldiv_start); end
        step();
        step();
        bus.muldiv_done = 1'b1;
        #1;
        checks++; if ({bus.muldiv_start, bus.stall_e} !== 2'b00) begin errors++; $display("FAIL b2b_done1: got %b expected 00", {bus.muldiv_start, bus.stall_e}); end
        step();
        bus.muldiv_done = 1'b0;
        #1;
        checks++; if ({bus.muldiv_start, bus.stall_e, bus.md_busy} !== 3'b110) begin errors++; $display("FAIL b2b_start2: got %b expected 110", {bus.muldiv_start, bus.stall_e, bus.md_busy}); end
        step();
        bus.muldiv_done = 1'b1;
        #1;
        checks++; if ({bus.md_busy, bus.stall_e} !== 2'b10) begin errors++; $display("FAIL b2b_done2: got %b expected 10", {bus.md_busy, bus.stall_e}); end
        step();
        clear_inputs();
        #1;
        checks++; if (bus.md_stall_cnt !== 4'd7) begin errors++; $display("FAIL b2b_cnt: got %0d expected 7", bus.md_stall_cnt); end
        step();
        $display("txn back_to_back done");
    endtask

    task automatic test_reset_busy();
        bus.muldiv_e = 1'b1;
        step();
        checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL rb_busy: got %b expected 1", bus.md_busy); end
        clear_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.md_busy, bus.stall_e, bus.muldiv_start} !== 3'b000) begin errors++; $display("FAIL rb_idle: got %b expected 000", {bus.md_busy, bus.stall_e, bus.muldiv_start}); end
        checks++; if ({bus.load_stall_cnt, bus.md_stall_cnt} !== 8'h00) begin errors++; $display("FAIL rb_cnt: got %h expected 00", {bus.load_stall_cnt, bus.md_stall_cnt}); end
        #1;
        rst_n = 1'b1;
        step();
        step();
        checks++; if ({bus.md_busy, bus.muldiv_start} !== 2'b00) begin errors++; $display("FAIL rb_no_restart: got %b expected 00", {bus.md_busy, bus.muldiv_start}); end
        $display("txn reset_busy done");
    endtask

    task automatic test_priority();
        bus.muldiv_e = 1'b1; bus.res_src_e = 2'b01; bus.rd_e = 5'd7; bus.rs1_d = 5'd7;
        #1;
        checks++; if ({bus.muldiv_start, bus.stall_f, bus.flush_e, bus.stall_e} !== 4'b1101) begin errors++; $display("FAIL pri_md_over_lu: got %b expected 1101", {bus.muldiv_start, bus.stall_f, bus.flush_e, bus.stall_e}); end
        step();
        bus.muldiv_done = 1'b1;
        #1;
        checks++; if ({bus.stall_f, bus.flush_e, bus.stall_e} !== 3'b110) begin errors++; $display("FAIL pri_lu_on_done: got %b expected 110", {bus.stall_f, bus.flush_e, bus.stall_e}); end
        step();
        clear_inputs();
        #1;
        checks++; if ({bus.load_stall_cnt, bus.md_stall_cnt} !== 8'h11) begin errors++; $display("FAIL pri_cnt: got %h expected 11", {bus.load_stall_cnt, bus.md_stall_cnt}); end
        $display("txn priority done");
    endtask

    task automatic test_saturation();
        bus.res_src_e = 2'b01; bus.rd_e = 5'd2; bus.rs2_d = 5'd2;
        for (int c = 0; c < 20; c++) step();
        checks++; if (bus.load_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_load: got %0d expected 15", bus.load_stall_cnt); end
        checks++; if (bus.md_stall_cnt !== 4'd1) begin errors++; $display("FAIL sat_md_untouched: got %0d expected 1", bus.md_stall_cnt); end
        bus.cnt_clr = 1'b1;
        step();
        checks++; if ({bus.load_stall_cnt, bus.md_stall_cnt} !== 8'h00) begin errors++; $display("FAIL sat_clr: got %h expected 00", {bus.load_stall_cnt, bus.md_stall_cnt}); end
        bus.cnt_clr = 1'b0;
        step();
        checks++; if (bus.load_stall_cnt !== 4'd1) begin errors++; $display("FAIL sat_after_clr: got %0d expected 1", bus.load_stall_cnt); end
        clear_inputs();
        bus.muldiv_e = 1'b1;
        for (int c = 0; c < 20; c++) step();
        checks++; if (bus.md_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_md: got %0d expected 15", bus.md_stall_cnt); end
        bus.muldiv_done = 1'b1;
        step();
        clear_inputs();
        #1;
        checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL sat_md_done: got %b expected 0", bus.md_busy); end
        $display("txn saturation done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_muldiv();
        test_back_to_back();
        test_reset_busy();
        test_priority();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
